// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared state, ALU, immediate and opcode encodings for the multicycle controller
// Purpose: single source of truth for the encodings used by the controller and its ALU decoder.
// Ports: none (package).
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JAL_PC   = 4'd11,
        S_JALR     = 4'd12,
        S_JALR_PC  = 4'd13,
        S_UPPER    = 4'd14
    } state_t;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLT   = 4'd5;
    localparam logic [3:0] ALU_SLTU  = 4'd6;
    localparam logic [3:0] ALU_SLL   = 4'd7;
    localparam logic [3:0] ALU_SRL   = 4'd8;
    localparam logic [3:0] ALU_SRA   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational funct3/funct7b5 to ALUControl decode
// Purpose: map the arithmetic fields of R- and I-type instructions onto ALU codes.
// Ports: i_funct3 (Instr[14:12]), i_funct7b5 (Instr[30]), i_op5 (1 = R-type),
//        o_alu_control (ALU code from riscv_pkg).
module alu_op_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_funct3)
            // Instr[30] is part of the immediate for addi, so only R-type may subtract.
            3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_alu_control = ALU_SLL;
            3'b010:  o_alu_control = ALU_SLT;
            3'b011:  o_alu_control = ALU_SLTU;
            3'b100:  o_alu_control = ALU_XOR;
            // srai keeps Instr[30] as the shift-type bit, so both formats honour it.
            3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_alu_control = ALU_OR;
            default: o_alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM with memory ready handshake and wait timeout
// Purpose: sequence a shared-memory multicycle datapath, one instruction per 3-5+ cycles.
// Ports: clk, reset (sync, active high); op/funct3/funct7b5 from the instruction register;
//        flags {V,C,N,Z} from the ALU; mem_ready handshake. Outputs are the datapath enables
//        and selects, illegal_op / trap_timeout one-cycle pulses, and state_dbg.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter logic [3:0] RESET_STATE    = 4'd0,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [3:0] flags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic [3:0] ALUControl,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic       trap_timeout,
    output logic [3:0] state_dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait_cnt;
    logic            w_mem_state;
    logic            w_timeout;
    logic            w_waiting;
    logic            w_br_taken;
    logic            w_br_bad;
    logic [3:0]      w_dec_alu;

    alu_op_decoder u_alu_dec (
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (w_dec_alu)
    );

    // A timeout wins over a same-cycle mem_ready so the abandoned access never writes.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);
    assign w_timeout   = w_mem_state && (r_wait_cnt == CW'(TIMEOUT_CYCLES));
    assign w_waiting   = w_mem_state && !mem_ready && !w_timeout;
    assign state_dbg   = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= state_t'(RESET_STATE);
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            // Memory states are only held while waiting, so "not waiting" means leaving.
            r_wait_cnt <= w_waiting ? r_wait_cnt + CW'(1) : '0;
        end
    end

    // flags: [0]=Z, [1]=N, [2]=C (1 = no borrow), [3]=V
    always_comb begin
        w_br_taken = 1'b0;
        w_br_bad   = 1'b0;
        case (funct3)
            3'b000:  w_br_taken = flags[0];
            3'b001:  w_br_taken = !flags[0];
            3'b100:  w_br_taken = flags[1] ^ flags[3];
            3'b101:  w_br_taken = !(flags[1] ^ flags[3]);
            3'b110:  w_br_taken = !flags[2];
            3'b111:  w_br_taken = flags[2];
            default: w_br_bad   = 1'b1;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        mem_req      = 1'b0;
        PCWrite      = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ImmSrc       = IMM_I;
        ALUControl   = ALU_ADD;
        RegWrite     = 1'b0;
        illegal_op   = 1'b0;
        trap_timeout = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (w_timeout) begin
                    trap_timeout = 1'b1;
                end else if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = S_BRANCH;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR;
                    OP_LUI, OP_AUIPC:  w_next = S_UPPER;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = op[5] ? IMM_S : IMM_I;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (w_timeout) begin
                    trap_timeout = 1'b1;
                    w_next       = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (w_timeout) begin
                    trap_timeout = 1'b1;
                    w_next       = S_FETCH;
                end else if (mem_ready) begin
                    MemWrite = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = w_dec_alu;
                w_next     = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ImmSrc     = IMM_I;
                ALUControl = w_dec_alu;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b00;
                ALUControl = ALU_SUB;
                PCWrite    = w_br_taken;
                illegal_op = w_br_bad;
                w_next     = S_FETCH;
            end
            S_JAL, S_JALR: begin
                // Link value OldPC+4 lands in ALUOut for the next cycle.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = (r_state == S_JAL) ? S_JAL_PC : S_JALR_PC;
            end
            S_JAL_PC, S_JALR_PC: begin
                // ResultSrc feeds the register file with the link from ALUOut; the PC
                // takes the fresh target from ALUResult over its own path.
                ALUSrcA   = (r_state == S_JAL_PC) ? 2'b01 : 2'b10;
                ALUSrcB   = 2'b01;
                ImmSrc    = (r_state == S_JAL_PC) ? IMM_J : IMM_I;
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
                PCWrite   = 1'b1;
                w_next    = S_FETCH;
            end
            S_UPPER: begin
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_U;
                if (op[5]) begin
                    ALUControl = ALU_PASSB;
                end else begin
                    ALUSrcA    = 2'b01;
                    ALUControl = ALU_ADD;
                end
                w_next = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase

        // Reset abandons the instruction: nothing is committed in the reset cycle.
        if (reset) begin
            PCWrite      = 1'b0;
            IRWrite      = 1'b0;
            MemWrite     = 1'b0;
            RegWrite     = 1'b0;
            illegal_op   = 1'b0;
            trap_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed table-driven bench for multicycle_controller
module tb_multicycle_controller;
    import riscv_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [3:0] flags;
    logic       mem_ready;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl, state_dbg;
    logic       illegal_op, trap_timeout;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .flags(flags), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .RegWrite(RegWrite), .illegal_op(illegal_op), .trap_timeout(trap_timeout),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [3:0] fl;
        int         cyc, rw, mw, pw, il;
        logic [3:0] alu3;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic add(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic [3:0] fl, input int cyc, input int rw, input int mw,
                       input int pw, input int il, input logic [3:0] alu3);
        vec_t v;
        v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.fl = fl;
        v.cyc = cyc; v.rw = rw; v.mw = mw; v.pw = pw; v.il = il; v.alu3 = alu3;
        vecs.push_back(v);
    endtask

    // Entered and left at negedge+1 with the FSM in FETCH.
    task automatic run_instr(input vec_t v);
        int cyc = 0, rw = 0, mw = 0, pw = 0, il = 0;
        logic [3:0] alu3 = 4'hF;
        op = v.op; funct3 = v.f3; funct7b5 = v.f7; flags = v.fl; mem_ready = 1'b1;
        #1;
        do begin
            if (cyc == 2) alu3 = ALUControl;
            rw += int'(RegWrite);
            mw += int'(MemWrite);
            pw += int'(PCWrite);
            il += int'(illegal_op);
            @(negedge clk); #1;
            cyc++;
        end while (state_dbg != S_FETCH && cyc < 20);
        chk({v.name, "_cycles"}, cyc, v.cyc);
        chk({v.name, "_regwrite"}, rw, v.rw);
        chk({v.name, "_memwrite"}, mw, v.mw);
        chk({v.name, "_pcwrite"}, pw, v.pw);
        chk({v.name, "_illegal"}, il, v.il);
        chk({v.name, "_alu"}, alu3, v.alu3);
    endtask

    logic [3:0] lw_st  [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    logic       lw_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int rw, first, ntrap, irw;
        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; flags = '0; mem_ready = 1'b1;

        @(negedge clk); @(negedge clk); #1;
        chk("rst_state", state_dbg, 0);
        chk("rst_mem_req", mem_req, 1);
        chk("rst_adrsrc", AdrSrc, 0);
        chk("rst_srca", ALUSrcA, 0);
        chk("rst_srcb", ALUSrcB, 2);
        chk("rst_alu", ALUControl, ALU_ADD);
        chk("rst_resultsrc", ResultSrc, 2);
        chk("rst_irwrite", IRWrite, 0);
        chk("rst_pcwrite", PCWrite, 0);
        chk("rst_regwrite", RegWrite, 0);
        reset = 1'b0;

        add("add",    OP_R,      3'b000, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_ADD);
        add("sub",    OP_R,      3'b000, 1'b1, 4'b0000, 4, 1, 0, 1, 0, ALU_SUB);
        add("sll",    OP_R,      3'b001, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_SLL);
        add("slt",    OP_R,      3'b010, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_SLT);
        add("sltu",   OP_R,      3'b011, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_SLTU);
        add("xor",    OP_R,      3'b100, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_XOR);
        add("srl",    OP_R,      3'b101, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_SRL);
        add("sra",    OP_R,      3'b101, 1'b1, 4'b0000, 4, 1, 0, 1, 0, ALU_SRA);
        add("or",     OP_R,      3'b110, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_OR);
        add("and",    OP_R,      3'b111, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_AND);
        add("addi7",  OP_I,      3'b000, 1'b1, 4'b0000, 4, 1, 0, 1, 0, ALU_ADD);
        add("srai",   OP_I,      3'b101, 1'b1, 4'b0000, 4, 1, 0, 1, 0, ALU_SRA);
        add("lw",     OP_LOAD,   3'b010, 1'b0, 4'b0000, 5, 1, 0, 1, 0, ALU_ADD);
        add("sw",     OP_STORE,  3'b010, 1'b0, 4'b0000, 4, 0, 1, 1, 0, ALU_ADD);
        add("beq_t",  OP_BRANCH, 3'b000, 1'b0, 4'b0001, 3, 0, 0, 2, 0, ALU_SUB);
        add("beq_n",  OP_BRANCH, 3'b000, 1'b0, 4'b0000, 3, 0, 0, 1, 0, ALU_SUB);
        add("bne_t",  OP_BRANCH, 3'b001, 1'b0, 4'b0000, 3, 0, 0, 2, 0, ALU_SUB);
        add("blt_t",  OP_BRANCH, 3'b100, 1'b0, 4'b0010, 3, 0, 0, 2, 0, ALU_SUB);
        add("bge_n",  OP_BRANCH, 3'b101, 1'b0, 4'b0010, 3, 0, 0, 1, 0, ALU_SUB);
        add("bltu_n", OP_BRANCH, 3'b110, 1'b0, 4'b0100, 3, 0, 0, 1, 0, ALU_SUB);
        add("bgeu_t", OP_BRANCH, 3'b111, 1'b0, 4'b0100, 3, 0, 0, 2, 0, ALU_SUB);
        add("br_bad", OP_BRANCH, 3'b010, 1'b0, 4'b0001, 3, 0, 0, 1, 1, ALU_SUB);
        add("jal",    OP_JAL,    3'b000, 1'b0, 4'b0000, 4, 1, 0, 2, 0, ALU_ADD);
        add("jalr",   OP_JALR,   3'b000, 1'b0, 4'b0000, 4, 1, 0, 2, 0, ALU_ADD);
        add("lui",    OP_LUI,    3'b000, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_PASSB);
        add("auipc",  OP_AUIPC,  3'b000, 1'b0, 4'b0000, 4, 1, 0, 1, 0, ALU_ADD);
        add("illegal", 7'b0000000, 3'b000, 1'b0, 4'b0000, 2, 0, 0, 1, 1, 4'hF);

        for (int i = 0; i < vecs.size(); i++) run_instr(vecs[i]);

        // Load with three wait cycles in MEMREAD.
        op = OP_LOAD; funct3 = 3'b010; rw = 0;
        for (int i = 0; i < 8; i++) begin
            mem_ready = lw_rdy[i];
            #1;
            chk($sformatf("lw_stall_state%0d", i), state_dbg, lw_st[i]);
            if (i == 3) chk("lw_stall_adrsrc", {mem_req, AdrSrc}, 2'b11);
            rw += int'(RegWrite);
            @(negedge clk); #1;
        end
        chk("lw_stall_regwrite", rw, 1);
        chk("lw_stall_end", state_dbg, S_FETCH);

        // jal second step detail.
        op = OP_JAL; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; end
        chk("jal_pc_state", state_dbg, S_JAL_PC);
        chk("jal_pc_strobes", {RegWrite, PCWrite, ImmSrc}, {1'b1, 1'b1, IMM_J});
        @(negedge clk); #1;
        chk("jal_next", state_dbg, S_FETCH);

        // Fetch timeout.
        mem_ready = 1'b0; first = -1; ntrap = 0; irw = 0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (trap_timeout) begin
                ntrap++;
                if (first < 0) first = i;
            end
            irw += int'(IRWrite);
            @(negedge clk);
        end
        #1;
        chk("timeout_first", first, 255);
        chk("timeout_pulses", ntrap, 1);
        chk("timeout_irwrite", irw, 0);
        chk("timeout_state", state_dbg, S_FETCH);

        // Reset while a store waits in MEMWRITE.
        mem_ready = 1'b1; op = OP_STORE; funct3 = 3'b010;
        for (int i = 0; i < 3; i++) begin @(negedge clk); #1; end
        mem_ready = 1'b0; #1;
        chk("st_wait_state", state_dbg, S_MEMWRITE);
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; #1;
        chk("st_reset_memwrite", MemWrite, 0);
        @(negedge clk);
        reset = 1'b0; #1;
        chk("st_after_reset_state", state_dbg, S_FETCH);
        chk("st_after_reset_memwrite", MemWrite, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
